inst_asm: RTL and testbench

INST_ASM -- requirements
Module: inst_asm

---
 rtl/inst_asm.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_inst_asm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/inst_asm.sv
`default_nettype none
// ============================================================================
// Module   : inst_asm
// Purpose  : Streaming ASCII line assembler producing RV32I machine code.
// Revision : 1.0
// ============================================================================
module inst_asm #(
  parameter int IMM_DIGITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        err,
  input  logic        inst_ready
);

  localparam int CW = $clog2(IMM_DIGITS + 4);

  typedef enum logic [2:0] {IDLE, MNEM, OPND, SKIP, DONE} state_t;
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_N} fmt_t;

  state_t         state_q, state_d;
  logic [39:0]    mnem_q, mnem_d;
  logic [2:0]     mcnt_q, mcnt_d;
  fmt_t           fmt_q, fmt_d;
  logic [2:0]     f3_q, f3_d;
  logic           alt_q, alt_d;
  logic [6:0]     opc_q, opc_d;
  logic [1:0]     opidx_q, opidx_d;
  logic           intok_q, intok_d;
  logic           end_q, end_d;
  logic [CW-1:0]  dcnt_q, dcnt_d;
  logic           hflag_q, hflag_d;
  logic [23:0]    acc_q, acc_d;
  logic [2:0][4:0] regs_q, regs_d;
  logic [31:0]    inst_q, inst_d;
  logic           err_q, err_d;

  logic        w_known, w_alt, w_fail, w_lower, w_term, w_space;
  logic        w_immk, w_tok_ok, w_have, w_anytok;
  fmt_t        w_fmt;
  logic [2:0]  w_f3;
  logic [6:0]  w_opc;
  logic [1:0]  w_nops;
  logic [4:0]  w_hex;
  logic [11:0] w_imm12;
  logic [31:0] w_enc;
  logic        w_unused;

  function automatic logic [4:0] hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9")      hexval = {1'b1, c[3:0]};
    else if ((c >= "a" && c <= "f") || (c >= "A" && c <= "F"))
                                   hexval = {1'b1, c[3:0] + 4'd9};
    else                           hexval = 5'd0;
  endfunction

  assign w_hex    = hexval(ch_data);
  assign w_lower  = (ch_data >= "a") && (ch_data <= "z");
  assign w_term   = (ch_data == 8'h0A) || (ch_data == ";");
  assign w_space  = (ch_data == " ");
  assign w_unused = ^acc_q[23:21];

  // Mnemonic table; characters are packed right-aligned, first letter highest.
  always_comb begin
    w_known = 1'b1;
    w_fmt   = F_R;
    w_f3    = 3'd0;
    w_alt   = 1'b0;
    w_opc   = 7'h33;
    case (mnem_q)
      {16'd0, "add"}:  ;
      {16'd0, "sub"}:  w_alt = 1'b1;
      {16'd0, "and"}:  w_f3 = 3'd7;
      {24'd0, "or"}:   w_f3 = 3'd6;
      {16'd0, "xor"}:  w_f3 = 3'd4;
      {16'd0, "slt"}:  w_f3 = 3'd2;
      {16'd0, "sll"}:  w_f3 = 3'd1;
      {16'd0, "srl"}:  w_f3 = 3'd5;
      {16'd0, "sra"}:  begin w_f3 = 3'd5; w_alt = 1'b1; end
      {8'd0, "addi"}:  begin w_fmt = F_I; w_opc = 7'h13; end
      {8'd0, "andi"}:  begin w_fmt = F_I; w_opc = 7'h13; w_f3 = 3'd7; end
      {16'd0, "ori"}:  begin w_fmt = F_I; w_opc = 7'h13; w_f3 = 3'd6; end
      {8'd0, "xori"}:  begin w_fmt = F_I; w_opc = 7'h13; w_f3 = 3'd4; end
      {8'd0, "slti"}:  begin w_fmt = F_I; w_opc = 7'h13; w_f3 = 3'd2; end
      {8'd0, "slli"}:  begin w_fmt = F_I; w_opc = 7'h13; w_f3 = 3'd1; end
      {8'd0, "srli"}:  begin w_fmt = F_I; w_opc = 7'h13; w_f3 = 3'd5; end
      {8'd0, "srai"}:  begin w_fmt = F_I; w_opc = 7'h13; w_f3 = 3'd5; w_alt = 1'b1; end
      {24'd0, "lw"}:   begin w_fmt = F_I; w_opc = 7'h03; w_f3 = 3'd2; end
      {8'd0, "jalr"}:  begin w_fmt = F_I; w_opc = 7'h67; end
      {24'd0, "sw"}:   begin w_fmt = F_S; w_opc = 7'h23; w_f3 = 3'd2; end
      {16'd0, "beq"}:  begin w_fmt = F_B; w_opc = 7'h63; end
      {16'd0, "bne"}:  begin w_fmt = F_B; w_opc = 7'h63; w_f3 = 3'd1; end
      {16'd0, "lui"}:  begin w_fmt = F_U; w_opc = 7'h37; end
      {16'd0, "jal"}:  begin w_fmt = F_J; w_opc = 7'h6F; end
      {16'd0, "nop"}:  begin w_fmt = F_N; w_opc = 7'h13; end
      default:         w_known = 1'b0;
    endcase
  end

  always_comb begin
    case (fmt_q)
      F_R, F_I, F_S, F_B: w_nops = 2'd3;
      F_U, F_J:           w_nops = 2'd2;
      default:            w_nops = 2'd0;
    endcase
  end

  // The immediate is always the last operand, so acc_q holds it at the terminator.
  assign w_immk   = (fmt_q != F_R) && (opidx_q == w_nops - 2'd1);
  assign w_tok_ok = w_immk ? (dcnt_q != '0)
                           : (intok_q && dcnt_q == CW'(2) && acc_q[7:5] == 3'd0);
  assign w_have   = end_q || (intok_q && w_tok_ok);
  assign w_anytok = end_q || intok_q;
  assign w_imm12  = acc_q[11:0] | {1'b0, alt_q, 10'd0};

  always_comb begin
    case (fmt_q)
      F_R:     w_enc = {1'b0, alt_q, 5'd0, regs_q[2], regs_q[1], f3_q, regs_q[0], opc_q};
      F_I:     w_enc = {w_imm12, regs_q[1], f3_q, regs_q[0], opc_q};
      F_S:     w_enc = {acc_q[11:5], regs_q[1], regs_q[0], f3_q, acc_q[4:0], opc_q};
      F_B:     w_enc = {acc_q[12], acc_q[10:5], regs_q[1], regs_q[0], f3_q,
                        acc_q[4:1], acc_q[11], opc_q};
      F_U:     w_enc = {acc_q[19:0], regs_q[0], opc_q};
      F_J:     w_enc = {acc_q[20], acc_q[10:1], acc_q[11], acc_q[19:12], regs_q[0], opc_q};
      default: w_enc = 32'h0000_0013;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mnem_d  = mnem_q;
    mcnt_d  = mcnt_q;
    fmt_d   = fmt_q;
    f3_d    = f3_q;
    alt_d   = alt_q;
    opc_d   = opc_q;
    opidx_d = opidx_q;
    intok_d = intok_q;
    end_d   = end_q;
    dcnt_d  = dcnt_q;
    hflag_d = hflag_q;
    acc_d   = acc_q;
    regs_d  = regs_q;
    inst_d  = inst_q;
    err_d   = err_q;
    w_fail  = 1'b0;
    if (state_q == DONE) begin
      if (inst_ready) begin
        state_d = IDLE;
        inst_d  = 32'd0;
        err_d   = 1'b0;
      end
    end else if (ch_valid) begin
      case (state_q)
        IDLE: begin
          if (w_lower) begin
            state_d = MNEM;
            mnem_d  = {32'd0, ch_data};
            mcnt_d  = 3'd1;
            opidx_d = 2'd0;
            intok_d = 1'b0;
            end_d   = 1'b0;
            dcnt_d  = '0;
            hflag_d = 1'b0;
            acc_d   = 24'd0;
            regs_d  = '0;
          end else if (!w_space && !w_term) begin
            w_fail = 1'b1;
          end
        end
        MNEM: begin
          if (w_lower) begin
            if (mcnt_q == 3'd5) w_fail = 1'b1;
            else begin
              mnem_d = {mnem_q[31:0], ch_data};
              mcnt_d = mcnt_q + 3'd1;
            end
          end else if ((w_space || w_term) && w_known) begin
            fmt_d = w_fmt;
            f3_d  = w_f3;
            alt_d = w_alt;
            opc_d = w_opc;
            if (!w_term)            state_d = OPND;
            else if (w_fmt == F_N) begin
              state_d = DONE;
              inst_d  = 32'h0000_0013;
              err_d   = 1'b0;
            end else                w_fail = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end
        OPND: begin
          if (w_space) begin
            if (intok_q) begin
              if (w_tok_ok) begin
                end_d   = 1'b1;
                intok_d = 1'b0;
              end else w_fail = 1'b1;
            end
          end else if (ch_data == ",") begin
            if (w_have && ({1'b0, opidx_q} + 3'd1 < {1'b0, w_nops})) begin
              opidx_d = opidx_q + 2'd1;
              intok_d = 1'b0;
              end_d   = 1'b0;
              dcnt_d  = '0;
              hflag_d = 1'b0;
              acc_d   = 24'd0;
            end else w_fail = 1'b1;
          end else if (w_term) begin
            if (w_anytok ? (w_have && opidx_q == w_nops - 2'd1) : (w_nops == 2'd0)) begin
              state_d = DONE;
              inst_d  = w_enc;
              err_d   = 1'b0;
            end else w_fail = 1'b1;
          end else if (end_q || w_nops == 2'd0) begin
            w_fail = 1'b1;
          end else if (!w_immk) begin
            if (!intok_q) begin
              if (ch_data == "x") intok_d = 1'b1;
              else                w_fail  = 1'b1;
            end else if (w_hex[4] && dcnt_q < CW'(2)) begin
              acc_d            = {acc_q[19:0], w_hex[3:0]};
              regs_d[opidx_q]  = {regs_q[opidx_q][0], w_hex[3:0]};
              dcnt_d           = dcnt_q + CW'(1);
            end else w_fail = 1'b1;
          end else begin
            if (w_hex[4] && !hflag_q && dcnt_q < CW'(IMM_DIGITS)) begin
              acc_d   = {acc_q[19:0], w_hex[3:0]};
              intok_d = 1'b1;
              dcnt_d  = dcnt_q + CW'(1);
            end else if (ch_data == "H" && dcnt_q != '0 && !hflag_q) begin
              hflag_d = 1'b1;
            end else w_fail = 1'b1;
          end
        end
        SKIP: begin
          if (w_term) begin
            state_d = DONE;
            inst_d  = 32'd0;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
      // A terminator that itself triggers the error skips SKIP entirely.
      if (w_fail) begin
        state_d = w_term ? DONE : SKIP;
        inst_d  = 32'd0;
        err_d   = w_term;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mnem_q  <= 40'd0;
      mcnt_q  <= 3'd0;
      fmt_q   <= F_R;
      f3_q    <= 3'd0;
      alt_q   <= 1'b0;
      opc_q   <= 7'd0;
      opidx_q <= 2'd0;
      intok_q <= 1'b0;
      end_q   <= 1'b0;
      dcnt_q  <= '0;
      hflag_q <= 1'b0;
      acc_q   <= 24'd0;
      regs_q  <= '0;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mnem_q  <= mnem_d;
      mcnt_q  <= mcnt_d;
      fmt_q   <= fmt_d;
      f3_q    <= f3_d;
      alt_q   <= alt_d;
      opc_q   <= opc_d;
      opidx_q <= opidx_d;
      intok_q <= intok_d;
      end_q   <= end_d;
      dcnt_q  <= dcnt_d;
      hflag_q <= hflag_d;
      acc_q   <= acc_d;
      regs_q  <= regs_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  assign ch_ready   = (state_q != DONE);
  assign inst_valid = (state_q == DONE);
  assign inst       = inst_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_asm.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_asm
// Purpose  : Directed self-checking bench for the inst_asm line assembler.
// Revision : 1.0
// ============================================================================
module tb_inst_asm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'd0;
  logic        inst_ready = 1'b0;
  logic        ch_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic        err;

  int total = 0;
  int bad   = 0;

  inst_asm #(.IMM_DIGITS(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .err        (err),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drives one character per cycle; the line must start with the DUT out of DONE.
  task automatic send_line(input string tag, input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      if (i == s.len() - 1) check({tag, "_pre"}, 32'(inst_valid), 32'd0);
      ch_valid = 1'b1;
      ch_data  = s[i];
    end
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] ei, input logic ee);
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_inst"},  inst, ei);
    check({tag, "_err"},   32'(err), 32'(ee));
  endtask

  task automatic consume(input string tag);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check({tag, "_drop"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic run(input string tag, input string s, input logic [31:0] ei, input logic ee);
    send_line(tag, s);
    expect_result(tag, ei, ee);
    consume(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",  inst, 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_ready", 32'(ch_ready), 32'd1);
    rst_n = 1'b1;

    run("add",   "add x01,x02,x03\n",    32'h003100B3, 1'b0);
    run("addi",  "addi x05,x00,07FH\n",  32'h07F00293, 1'b0);
    run("lui",   "lui x0A,12345H\n",     32'h12345537, 1'b0);
    run("sw",    "sw x02,x01,008H;",     32'h00112423, 1'b0);
    run("nop",   "nop\n",                32'h00000013, 1'b0);
    run("sub",   "sub x01,x02,x03\n",    32'h403100B3, 1'b0);
    run("srai",  "srai x01,x02,003H\n",  32'h40315093, 1'b0);
    run("beq",   "  beq x01, x02 ,010H\n", 32'h00208863, 1'b0);
    run("jal",   "jal x01,000010H\n",    32'h010000EF, 1'b0);

    send_line("empty", "\n");
    check("empty_valid", 32'(inst_valid), 32'd0);

    run("mul",     "mul x01,x02,x03\n",       32'd0, 1'b1);
    run("after1",  "and x01,x02,x03\n",       32'h003170B3, 1'b0);
    run("badreg",  "add x20,x01,x02\n",       32'd0, 1'b1);
    run("after2",  "xor x01,x02,x03\n",       32'h003140B3, 1'b0);
    run("digits",  "addi x01,x02,1234567H\n", 32'd0, 1'b1);
    run("longmn",  "abcdef x01\n",            32'd0, 1'b1);
    run("count",   "add x01,x02\n",           32'd0, 1'b1);
    run("after3",  "addi x01,x02,FFFFFFH\n",  32'hFFF10093, 1'b0);

    // Backpressure: result held while ch_valid is pending and inst_ready is low.
    send_line("bp", "lui x0A,12345H\n");
    expect_result("bp", 32'h12345537, 1'b0);
    ch_valid = 1'b1;
    ch_data  = "n";
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_chready", 32'(ch_ready), 32'd0);
      check("bp_valid",   32'(inst_valid), 32'd1);
      check("bp_inst",    inst, 32'h12345537);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("bp_drop",  32'(inst_valid), 32'd0);
    check("bp_ready", 32'(ch_ready), 32'd1);
    send_line("bp_next", "op\n");
    expect_result("bp_next", 32'h00000013, 1'b0);
    consume("bp_next");

    send_line("mid", "add x01,");
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(inst_valid), 32'd0);
    check("mid_inst",  inst, 32'd0);
    check("mid_err",   32'(err), 32'd0);
    check("mid_ready", 32'(ch_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run("rst_or", "or x03,x04,x05\n", 32'h005261B3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
